// File: rtl/up_pkg.sv
// Shared definitions for the 16-bit accumulator processor memory bus:
// widths, bus encodings, responder state encoding and instruction opcodes.
package up_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] OP_ADD   = 8'd3;
  localparam logic [7:0] OP_STORE = 8'd4;
  localparam logic [7:0] OP_LOAD  = 8'd5;
  localparam logic [7:0] OP_JUMP  = 8'd6;

  // Instruction word: opcode in the high byte, operand address in the low byte.
  function automatic logic [DATA_W-1:0] make_instr(input logic [7:0] op,
                                                   input logic [ADDR_W-1:0] operand);
    return {op, operand};
  endfunction

endpackage

// File: rtl/up_mem_array.sv
// 256 x 16 word store: one synchronous write port and one registered,
// read-enabled read port. Contents are never reset.
import up_pkg::*;

module up_mem_array (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/up_mem_responder.sv
// Memory-side responder for the processor MAR/MDR bus: wait-state FSM,
// request capture, loader port with priority in IDLE, and drop reporting.
import up_pkg::*;

module up_mem_responder #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_readwrite,
  input  logic [ADDR_W-1:0] mar,
  input  logic [DATA_W-1:0] mdr_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              mem_busy,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_drop
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_valid;
  logic [DATA_W-1:0] arr_rdata;

  logic              load_go;
  logic              req_go;
  logic              enter_resp;
  logic              cur_rw;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              arr_we;
  logic              arr_re;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;

  // With no wait states RESP is entered on the capture edge itself, so the
  // access uses the live bus instead of the not-yet-loaded capture registers.
  always_comb begin
    load_go    = (state == ST_IDLE) && load_en;
    req_go     = (state == ST_IDLE) && !load_en && mem_req;
    cur_rw     = rw_q;
    cur_addr   = addr_q;
    cur_wdata  = wdata_q;
    if (state == ST_IDLE) begin
      cur_rw    = mem_readwrite;
      cur_addr  = mar;
      cur_wdata = mdr_wdata;
    end
    enter_resp = (req_go && NO_WAIT) || ((state == ST_WAIT) && (cnt == 4'd1));
    arr_we     = load_go || (enter_resp && (cur_rw == RW_WRITE));
    arr_re     = enter_resp && (cur_rw == RW_READ);
    arr_waddr  = load_go ? load_addr : cur_addr;
    arr_wdata  = load_go ? load_data : cur_wdata;
  end

  always_ff @(posedge clk) begin
    if (req_go) begin
      addr_q  <= mar;
      rw_q    <= mem_readwrite;
      wdata_q <= mdr_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      mem_ack   <= 1'b0;
      mem_busy  <= 1'b0;
      load_drop <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      mem_ack   <= enter_resp;
      load_drop <= load_en && (state != ST_IDLE);
      rd_valid  <= rd_valid | arr_re;
      case (state)
        ST_IDLE: begin
          if (req_go) begin
            cnt      <= WAIT_INIT;
            state    <= NO_WAIT ? ST_RESP : ST_WAIT;
            mem_busy <= 1'b1;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_RESP;
        end
        ST_RESP: begin
          state    <= ST_IDLE;
          mem_busy <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          mem_busy <= 1'b0;
        end
      endcase
    end
  end

  // Until the first read completes after reset the read register is unknown,
  // so the bus shows zero instead.
  assign mem_rdata = rd_valid ? arr_rdata : '0;

  up_mem_array u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (cur_addr),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_up_mem_responder.sv
// Directed bench for up_mem_responder: four instances with different wait-state
// settings, a memory model and a scoreboard of expected read data per ack.
import up_pkg::*;

module tb_up_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req   [4];
  logic        rw    [4];
  logic [7:0]  mar   [4];
  logic [15:0] wd    [4];
  logic        len   [4];
  logic [7:0]  laddr [4];
  logic [15:0] ld    [4];
  logic [15:0] rd    [4];
  logic        ack   [4];
  logic        busy  [4];
  logic        drop  [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    up_mem_responder #(
      .WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 5 : 3)
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .mem_req       (req[g]),
      .mem_readwrite (rw[g]),
      .mar           (mar[g]),
      .mdr_wdata     (wd[g]),
      .mem_rdata     (rd[g]),
      .mem_ack       (ack[g]),
      .mem_busy      (busy[g]),
      .load_en       (len[g]),
      .load_addr     (laddr[g]),
      .load_data     (ld[g]),
      .load_drop     (drop[g])
    );
  end

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb [$];
  logic [15:0] model [4][256];
  logic [15:0] last_rd [4];

  function automatic int wc_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      2:       return 5;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    len[i] = 1'b1; laddr[i] = a; ld[i] = d;
    model[i][a] = d;
    @(negedge clk);
    len[i] = 1'b0;
    check("load_drop_idle", drop[i], 1'b0);
  endtask

  task automatic wait_ack(input int i, input int k0, input int lat, input string tag);
    int k;
    bit got;
    logic [15:0] e;
    k = k0; got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      len[i] = 1'b0;
      if (ack[i]) got = 1'b1;
      else check({tag, "_busy_wait"}, busy[i], 1'b1);
    end
    check({tag, "_ack_seen"}, got, 1'b1);
    if (got) begin
      e = sb.pop_front();
      check({tag, "_latency"}, k, lat);
      check({tag, "_rdata"}, rd[i], e);
      check({tag, "_busy_resp"}, busy[i], 1'b1);
    end else begin
      sb.delete();
    end
    req[i] = 1'b0;
    @(negedge clk);
    check({tag, "_ack_pulse"}, ack[i], 1'b0);
    check({tag, "_busy_idle"}, busy[i], 1'b0);
  endtask

  task automatic access(input int i, input logic r, input logic [7:0] a,
                        input logic [15:0] d, input string tag);
    logic [15:0] e;
    @(negedge clk);
    req[i] = 1'b1; rw[i] = r; mar[i] = a; wd[i] = d;
    if (r == RW_READ) begin
      e = model[i][a];
      last_rd[i] = e;
    end else begin
      e = last_rd[i];
      model[i][a] = d;
    end
    sb.push_back(e);
    wait_ack(i, 0, wc_of(i) + 1, tag);
  endtask

  task automatic b2b(input int i);
    int k, acks, prev, lows, w;
    logic [7:0] a;
    w = wc_of(i);
    @(negedge clk);
    a = 8'd0;
    req[i] = 1'b1; rw[i] = RW_READ; mar[i] = a;
    sb.push_back(model[i][a]);
    k = 0; acks = 0; prev = 0; lows = 0;
    while (acks < 3 && k < 100) begin
      @(negedge clk);
      k++;
      if (!busy[i]) lows++;
      if (ack[i]) begin
        acks++;
        check("b2b_rdata", rd[i], sb.pop_front());
        if (acks == 1) check("b2b_first_latency", k, w + 1);
        else begin
          check("b2b_spacing", k - prev, w + 2);
          check("b2b_idle_cycles", lows, 1);
        end
        prev = k; lows = 0;
        if (acks < 3) begin
          a = a + 8'd1;
          mar[i] = a;
          sb.push_back(model[i][a]);
        end else begin
          req[i] = 1'b0;
        end
      end
    end
    check("b2b_ack_count", acks, 3);
    sb.delete();
    last_rd[i] = model[i][8'd2];
    @(negedge clk);
    check("b2b_busy_after", busy[i], 1'b0);
  endtask

  initial begin
    bit seen;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req[i] = 1'b0; rw[i] = RW_READ; mar[i] = '0; wd[i] = '0;
      len[i] = 1'b0; laddr[i] = '0; ld[i] = '0; last_rd[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("reset_ack", ack[i], 1'b0);
      check("reset_busy", busy[i], 1'b0);
      check("reset_rdata", rd[i], 16'h0000);
      check("reset_drop", drop[i], 1'b0);
    end
    reset = 1'b1;

    // Program words and sweep data for every instance.
    load(0, 8'h00, make_instr(OP_ADD, 8'h10));
    load(0, 8'h10, 16'h00AB);
    load(0, 8'h30, 16'h5555);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) load(i, 8'h00, 16'hA000 + 16'(i * 16));
      load(i, 8'h01, 16'hB001 + 16'(i * 16));
      load(i, 8'h02, 16'hC002 + 16'(i * 16));
    end

    access(0, RW_READ, 8'h00, 16'h0, "read_0");
    check("read_0_value", rd[0], 16'h0310);
    access(0, RW_READ, 8'h10, 16'h0, "read_10");
    check("read_10_value", rd[0], 16'h00AB);
    access(0, RW_WRITE, 8'h20, 16'h1234, "write_20");
    access(0, RW_READ, 8'h20, 16'h0, "read_20");
    check("read_20_value", rd[0], 16'h1234);

    b2b(1);
    b2b(0);
    b2b(2);

    // Loader strobe during WAIT is dropped and reported one cycle later.
    @(negedge clk);
    req[0] = 1'b1; rw[0] = RW_READ; mar[0] = 8'h10;
    sb.push_back(model[0][8'h10]);
    last_rd[0] = model[0][8'h10];
    @(negedge clk);
    check("drop_wait_ack", ack[0], 1'b0);
    check("drop_wait_busy", busy[0], 1'b1);
    len[0] = 1'b1; laddr[0] = 8'h30; ld[0] = 16'hDEAD;
    @(negedge clk);
    len[0] = 1'b0;
    check("drop_pulse", drop[0], 1'b1);
    check("drop_read_ack", ack[0], 1'b1);
    check("drop_read_rdata", rd[0], sb.pop_front());
    req[0] = 1'b0;
    @(negedge clk);
    check("drop_pulse_end", drop[0], 1'b0);
    access(0, RW_READ, 8'h30, 16'h0, "read_30");
    check("read_30_kept", rd[0], 16'h5555);

    // Load and request together: load wins, request captured a cycle later.
    @(negedge clk);
    len[0] = 1'b1; laddr[0] = 8'h50; ld[0] = 16'h7777;
    req[0] = 1'b1; rw[0] = RW_READ; mar[0] = 8'h50;
    model[0][8'h50] = 16'h7777;
    sb.push_back(16'h7777);
    last_rd[0] = 16'h7777;
    @(negedge clk);
    len[0] = 1'b0;
    check("simul_req_deferred", busy[0], 1'b0);
    check("simul_no_ack", ack[0], 1'b0);
    check("simul_no_drop", drop[0], 1'b0);
    wait_ack(0, 1, wc_of(0) + 2, "simul");

    // Reset in the second WAIT cycle of a write kills it without an ack.
    load(3, 8'h40, 16'h1111);
    @(negedge clk);
    req[3] = 1'b1; rw[3] = RW_WRITE; mar[3] = 8'h40; wd[3] = 16'hBEEF;
    @(negedge clk);
    check("rst_first_wait_busy", busy[3], 1'b1);
    @(negedge clk);
    check("rst_second_wait_ack", ack[3], 1'b0);
    reset = 1'b0;
    req[3] = 1'b0;
    #1;
    check("rst_async_ack", ack[3], 1'b0);
    check("rst_async_busy", busy[3], 1'b0);
    check("rst_async_rdata", rd[3], 16'h0000);
    check("rst_async_drop", drop[3], 1'b0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack[3]) seen = 1'b1;
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) last_rd[i] = '0;
    repeat (4) begin
      @(negedge clk);
      if (ack[3] || busy[3]) seen = 1'b1;
    end
    check("rst_no_ack", seen, 1'b0);
    access(3, RW_READ, 8'h40, 16'h0, "rst_read_40");
    check("rst_40_kept", rd[3], 16'h1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/up_mem_responder.md
# up_mem_responder

Memory-side responder for the 16-bit accumulator processor: it services the processor's MAR/MDR read and write requests against a 256 x 16 word store, with configurable wait states and a single-cycle acknowledge. A separate loader port preloads programs and data before or between processor accesses. It sits between the processor core and the top level, as the other end of the processor's memory bus.

## Interface
- `WAIT_CYCLES`, default 1: wait states inserted between request capture and response; 0 to 15 legal.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `mem_req` in 1: request valid; held high by processor until `mem_ack`.
- `mem_readwrite` in 1: 1 = read, 0 = write (active-low write); sampled only with `mem_req`.
- `mar` in 8: word address.
- `mdr_wdata` in 16: write data from processor MDR.
- `mem_rdata` out 16: read data to processor MDR.
- `mem_ack` out 1: one-cycle completion pulse.
- `mem_busy` out 1: high while a request is in flight (WAIT or RESP).
- `load_en` in 1: loader write strobe.
- `load_addr` in 8: loader address.
- `load_data` in 16: loader data; bits [15:8] are the opcode and bits [7:0] are the operand address for instruction words.
- `load_drop` out 1: one-cycle pulse when a `load_en` is ignored.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE behaviour:
  - `load_en` = 1: write `load_data` to `load_addr`; `mem_req` is not accepted that cycle. The loader has priority.
  - Else `mem_req` = 1: capture `mar`, `mem_readwrite` and `mdr_wdata`, and load the wait counter with `WAIT_CYCLES`.
  - Next state is WAIT if `WAIT_CYCLES` > 0, else RESP.
- WAIT: counter decrements each cycle. When the counter reaches 1, go to RESP on the next edge. Input changes are ignored; the captured values are used.
- Entering RESP:
  - A read registers `array[addr]` into `mem_rdata`.
  - A write commits the captured data to the array.
  - `mem_ack` = 1 for exactly the RESP cycle, then the FSM returns to IDLE unconditionally.
- `mem_rdata` holds its value until the next read completes. Writes do not change it.
- `load_en` in WAIT or RESP is discarded, and `load_drop` pulses on the following cycle.
- Address is 8 bits and covers the full array; there is no out-of-range case.
- Array contents are not cleared by reset.

## Timing
- Reset values: state IDLE, `mem_ack` 0, `mem_busy` 0, `mem_rdata` 16'h0000, `load_drop` 0, counter 0.
- Request latency: `mem_req` sampled high at edge N gives `mem_ack` high during cycle N+WAIT_CYCLES+1. With `WAIT_CYCLES`=0, ack appears in the cycle right after capture.
- Handshake:
  - Requester keeps `mem_req` high until it samples `mem_ack`, then drops it.
  - A `mem_req` still high in the IDLE cycle after RESP is a new request. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- `mem_busy` is registered: high from the cycle after capture through RESP inclusive.
- Simultaneous events:
  - `load_en` and `mem_req` together in IDLE: load wins and the request waits.
  - A load and a read of the same address in consecutive cycles: the read returns the loaded data.
- Reset mid-operation (in WAIT or RESP before the edge entering RESP): the in-flight write is dropped, the FSM goes to IDLE, and the ack is not issued. A write committed on the edge into RESP is retained.

## Structure
- Package `up_pkg`:
  - `ADDR_W`=8, `DATA_W`=16.
  - `RW_READ`=1'b1, `RW_WRITE`=1'b0.
  - State encoding.
  - Opcode constants ADD=3, STORE=4, LOAD=5, JUMP=6, shared with the processor and benches.
- Sub-module `up_mem_array`: 256 x 16, one synchronous write port and one registered read port, no reset. The responder multiplexes loader and processor writes onto that one write port.
- The responder holds the FSM, wait counter, capture registers and drop logic.

## Test plan
- Reset, then load 16'h0310 to address 0 and 16'h00AB to address 0x10. Read address 0 with `WAIT_CYCLES`=1 -> `mem_ack` in cycle N+2 with `mem_rdata`=16'h0310. Read 0x10 -> 16'h00AB.
- Write 16'h1234 to 0x20 (`mem_readwrite`=0), then read 0x20 -> 16'h1234. During the write ack, `mem_rdata` is unchanged from the previous read.
- Sweep `WAIT_CYCLES` over 0, 1, 5 with back-to-back reads -> ack spacing of 2, 3 and 7 cycles; `mem_busy` is never high in IDLE.
- Pulse `load_en` to 0x30 during WAIT -> `load_drop` pulses one cycle later and 0x30 still holds its old value. Assert `load_en` and `mem_req` together in IDLE -> the load is written and the request is captured one cycle later.
- Start a write of 16'hBEEF to 0x40 with `WAIT_CYCLES`=3 and assert `reset` low in the second WAIT cycle -> no ack, outputs return to reset values, and 0x40 keeps its prior contents.
- Preload an ADD/STORE/JUMP program, connect the processor core and run -> the final accumulator is stored at the expected address with the expected sum.
